// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the single FIFO write port among NUM_REQ same-clock producers.
// Define FIFO_ARB_BURST_EN to hold a grant for a burst; otherwise every grant carries one word.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 8,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BC_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     fifo_shift,
  output logic [WIDTH-1:0]         fifo_data,
  input  logic                     fifo_full,
  output logic                     grant_valid,
  output logic [ID_W-1:0]          grant_id,
  output logic [BC_W-1:0]          beat_count
);

  // Handshake: requester i's word moves on a cycle where req_valid[i] && req_ready[i];
  // the requester keeps data and last stable until then, and may withdraw to end its grant.

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   last;
  logic [WIDTH-1:0]  req_word [NUM_REQ];

  logic              pick_found;
  logic [ID_W-1:0]   pick_id;
  logic              in_grant;
  logic              cur_valid;
  logic              xfer;
  logic              release_grant;
  logic [BC_W-1:0]   beat_next;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
    assign req_word[g] = req_data[g*WIDTH +: WIDTH];
  end

  // Search last+1, last+2, ... wrapping at NUM_REQ, so the previous winner goes to the back.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    ptr);
    logic            found;
    logic [ID_W-1:0] id;
    logic [ID_W:0]   idx;
    found = 1'b0;
    id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!found && valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        id    = idx[ID_W-1:0];
      end
    end
    return {found, id};
  endfunction

  always_comb begin
    {pick_found, pick_id} = rr_pick(req_valid, last);
  end

  assign in_grant    = (state == GRANT);
  assign grant_valid = in_grant;
  assign cur_valid   = req_valid[grant_id];

  // A word presented while reset is high is never acknowledged.
  assign xfer       = in_grant && !reset && cur_valid && !fifo_full;
  assign fifo_shift = xfer;
  assign fifo_data  = req_word[grant_id];

  always_comb begin
    req_ready = '0;
    if (in_grant && !reset) begin
      req_ready = (NUM_REQ'(1) << grant_id) & {NUM_REQ{!fifo_full}};
    end
  end

`ifdef FIFO_ARB_BURST_EN
  localparam logic [BC_W-1:0] MAX_BEAT = BC_W'(MAX_BURST);

  logic [BC_W-1:0] beat_inc;
  logic            at_limit;

  assign beat_inc  = beat_count + 1'b1;
  assign at_limit  = (beat_inc == MAX_BEAT);
  assign beat_next = (beat_count == MAX_BEAT) ? beat_count : beat_inc;
  // last and the burst limit together still give one release.
  assign release_grant = (xfer && (req_last[grant_id] || at_limit)) || !cur_valid;
`else
  logic unused_last;

  assign unused_last   = ^req_last;
  assign beat_next     = BC_W'(1);
  assign release_grant = xfer || !cur_valid;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      grant_id   <= '0;
      beat_count <= '0;
      last       <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id   <= pick_id;
            last       <= pick_id;
            beat_count <= '0;
            state      <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) beat_count <= beat_next;
          if (release_grant) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: per-cycle expected grant/handshake values plus a FIFO-order scoreboard.
// Expectations follow whichever build is selected by FIFO_ARB_BURST_EN.
module tb_fifo_write_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 16;
  localparam int MAX_BURST = 8;
  localparam int ID_W      = 2;
  localparam int BC_W      = 4;
  localparam int DEPTH     = 16;
  localparam int LAST_NONE  = 0;
  localparam int LAST_ALL   = 1;
  localparam int LAST_FINAL = 2;

  logic                     clock;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_shift;
  logic [WIDTH-1:0]         fifo_data;
  logic                     fifo_full;
  logic                     grant_valid;
  logic [ID_W-1:0]          grant_id;
  logic [BC_W-1:0]          beat_count;

  fifo_write_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .WIDTH    (WIDTH),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_shift (fifo_shift),
    .fifo_data  (fifo_data),
    .fifo_full  (fifo_full),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .beat_count (beat_count)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  logic [WIDTH-1:0] exp_q[$];
  int               n_cmp;
  int               n_err;
  int               n_extra;

  logic [WIDTH-1:0] src_data [NUM_REQ][DEPTH];
  logic             src_last [NUM_REQ][DEPTH];
  int               src_len  [NUM_REQ];
  int               src_pos  [NUM_REQ];

  logic               s_gv;
  logic [ID_W-1:0]    s_gid;
  logic               s_shift;
  logic [NUM_REQ-1:0] s_ready;
  logic [BC_W-1:0]    s_beat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_src(input int r, input logic [WIDTH-1:0] base, input int n, input int last_mode);
    for (int k = 0; k < n; k++) begin
      src_data[r][k] = base + WIDTH'(k);
      src_last[r][k] = (last_mode == LAST_ALL) || (last_mode == LAST_FINAL && k == n - 1);
    end
    src_len[r] = n;
    src_pos[r] = 0;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_pos[i] < src_len[i]) begin
        req_valid[i]                = 1'b1;
        req_data[i*WIDTH +: WIDTH]  = src_data[i][src_pos[i]];
        req_last[i]                 = src_last[i][src_pos[i]];
      end else begin
        req_valid[i]                = 1'b0;
        req_data[i*WIDTH +: WIDTH]  = '0;
        req_last[i]                 = 1'b0;
      end
    end
  endtask

  // One clock: sample on the falling edge, advance requesters after the rising edge.
  task automatic cycle();
    logic [NUM_REQ-1:0] acc;
    @(negedge clock);
    s_gv    = grant_valid;
    s_gid   = grant_id;
    s_shift = fifo_shift;
    s_ready = req_ready;
    s_beat  = beat_count;
    acc     = req_valid & req_ready;
    if (fifo_shift) begin
      if (exp_q.size() == 0) n_extra++;
      else check("fifo_data", 32'(fifo_data), 32'(exp_q.pop_front()));
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < NUM_REQ; i++) if (acc[i]) src_pos[i]++;
    drive_reqs();
  endtask

  task automatic ec(input string tag, input int gv, input int gid, input int shift,
                    input int ready, input int beat);
    cycle();
    check({tag, ".grant_valid"}, 32'(s_gv), gv);
    check({tag, ".grant_id"},    32'(s_gid), gid);
    check({tag, ".fifo_shift"},  32'(s_shift), shift);
    check({tag, ".req_ready"},   32'(s_ready), ready);
    check({tag, ".beat_count"},  32'(s_beat), beat);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    n_cmp = 0; n_err = 0; n_extra = 0;
    reset = 1'b1; fifo_full = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end

    // reset with every requester valid, then single-word round robin
    for (int i = 0; i < NUM_REQ; i++) load_src(i, 16'(16'h1000 + i*16), 2, LAST_ALL);
    drive_reqs();
    ec("reset0", 0, 0, 0, 0, 0);
    ec("reset1", 0, 0, 0, 0, 0);
    reset = 1'b0;
    ec("fair_first_idle", 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(16'(16'h1000 + (k % 4)*16 + k / 4));
      ec("fair_grant", 1, k % 4, 1, 1 << (k % 4), 0);
      ec("fair_idle", 0, k % 4, 0, 0, 1);
    end

    // requester 2 sends a three-word packet
    load_src(2, 16'hA001, 3, LAST_FINAL);
    drive_reqs();
    exp_q.push_back(16'hA001); exp_q.push_back(16'hA002); exp_q.push_back(16'hA003);
    ec("burst_idle", 0, 3, 0, 0, 1);
`ifdef FIFO_ARB_BURST_EN
    ec("burst_w1", 1, 2, 1, 4, 0);
    ec("burst_w2", 1, 2, 1, 4, 1);
    ec("burst_w3", 1, 2, 1, 4, 2);
    ec("burst_end", 0, 2, 0, 0, 3);
`else
    for (int k = 0; k < 3; k++) begin
      ec("single_w", 1, 2, 1, 4, 0);
      ec("single_idle", 0, 2, 0, 0, 1);
    end
`endif

    // backpressure on requester 1's second word
    load_src(1, 16'hB001, 3, LAST_FINAL);
    drive_reqs();
    exp_q.push_back(16'hB001); exp_q.push_back(16'hB002); exp_q.push_back(16'hB003);
`ifdef FIFO_ARB_BURST_EN
    ec("bp_idle", 0, 2, 0, 0, 3);
    ec("bp_w1", 1, 1, 1, 2, 0);
    fifo_full = 1'b1;
    ec("bp_full0", 1, 1, 0, 0, 1);
    ec("bp_full1", 1, 1, 0, 0, 1);
    fifo_full = 1'b0;
    ec("bp_w2", 1, 1, 1, 2, 1);
    ec("bp_w3", 1, 1, 1, 2, 2);
    ec("bp_end", 0, 1, 0, 0, 3);
`else
    ec("bp_idle", 0, 2, 0, 0, 1);
    ec("bp_w1", 1, 1, 1, 2, 0);
    ec("bp_idle1", 0, 1, 0, 0, 1);
    fifo_full = 1'b1;
    ec("bp_full0", 1, 1, 0, 0, 0);
    ec("bp_full1", 1, 1, 0, 0, 0);
    fifo_full = 1'b0;
    ec("bp_w2", 1, 1, 1, 2, 0);
    ec("bp_idle2", 0, 1, 0, 0, 1);
    ec("bp_w3", 1, 1, 1, 2, 0);
    ec("bp_end", 0, 1, 0, 0, 1);
`endif

`ifdef FIFO_ARB_BURST_EN
    // burst limit: requester 0 streams 12 words without last, requester 3 waiting
    load_src(0, 16'h0101, 12, LAST_NONE);
    drive_reqs();
    for (int k = 0; k < 8; k++) exp_q.push_back(16'(16'h0101 + k));
    ec("lim_idle", 0, 1, 0, 0, 3);
    load_src(3, 16'h0300, 1, LAST_FINAL);
    drive_reqs();
    for (int b = 0; b < 8; b++) ec("lim_w", 1, 0, 1, 1, b);
    exp_q.push_back(16'h0300);
    ec("lim_release", 0, 0, 0, 0, 8);
    ec("lim_req3", 1, 3, 1, 8, 0);
    ec("lim_idle3", 0, 3, 0, 0, 1);
    for (int k = 8; k < 12; k++) exp_q.push_back(16'(16'h0101 + k));
    for (int b = 0; b < 4; b++) ec("lim_resume", 1, 0, 1, 1, b);
    ec("lim_withdraw", 1, 0, 0, 1, 4);
    ec("lim_end", 0, 0, 0, 0, 4);
`else
    // requesters 0 and 1 interleave one word per grant
    load_src(0, 16'h0C01, 3, LAST_NONE);
    load_src(1, 16'h0D01, 3, LAST_NONE);
    drive_reqs();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(16'(16'h0C01 + k));
      exp_q.push_back(16'(16'h0D01 + k));
    end
    ec("ilv_idle", 0, 1, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      ec("ilv_r0", 1, 0, 1, 1, 0);
      ec("ilv_i0", 0, 0, 0, 0, 1);
      ec("ilv_r1", 1, 1, 1, 2, 0);
      ec("ilv_i1", 0, 1, 0, 0, 1);
    end
`endif

    // reset in the middle of a grant; requester 3 arrives with the reset
    load_src(2, 16'hE001, 4, LAST_NONE);
    drive_reqs();
`ifdef FIFO_ARB_BURST_EN
    exp_q.push_back(16'hE001); exp_q.push_back(16'hE002);
    ec("mr_idle", 0, 0, 0, 0, 4);
    ec("mr_w1", 1, 2, 1, 4, 0);
    ec("mr_w2", 1, 2, 1, 4, 1);
    reset = 1'b1;
    load_src(3, 16'hF001, 1, LAST_FINAL);
    drive_reqs();
    ec("mr_in_reset", 1, 2, 0, 0, 2);
    reset = 1'b0;
    exp_q.push_back(16'hE003); exp_q.push_back(16'hE004); exp_q.push_back(16'hF001);
    ec("mr_after", 0, 0, 0, 0, 0);
    ec("mr_w3", 1, 2, 1, 4, 0);
    ec("mr_w4", 1, 2, 1, 4, 1);
    ec("mr_withdraw", 1, 2, 0, 4, 2);
    ec("mr_idle2", 0, 2, 0, 0, 2);
    ec("mr_req3", 1, 3, 1, 8, 0);
    ec("mr_end", 0, 3, 0, 0, 1);
`else
    exp_q.push_back(16'hE001);
    ec("mr_idle", 0, 1, 0, 0, 1);
    ec("mr_w1", 1, 2, 1, 4, 0);
    ec("mr_idle1", 0, 2, 0, 0, 1);
    reset = 1'b1;
    load_src(3, 16'hF001, 1, LAST_FINAL);
    drive_reqs();
    ec("mr_in_reset", 1, 2, 0, 0, 0);
    reset = 1'b0;
    exp_q.push_back(16'hE002); exp_q.push_back(16'hF001);
    exp_q.push_back(16'hE003); exp_q.push_back(16'hE004);
    ec("mr_after", 0, 0, 0, 0, 0);
    ec("mr_w2", 1, 2, 1, 4, 0);
    ec("mr_i2", 0, 2, 0, 0, 1);
    ec("mr_req3", 1, 3, 1, 8, 0);
    ec("mr_i3", 0, 3, 0, 0, 1);
    ec("mr_w3", 1, 2, 1, 4, 0);
    ec("mr_i4", 0, 2, 0, 0, 1);
    ec("mr_w4", 1, 2, 1, 4, 0);
    ec("mr_end", 0, 2, 0, 0, 1);
`endif

    // ---------------- final report ----------------
    check("words_missing", 32'(exp_q.size()), 0);
    check("words_extra", 32'(n_extra), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the single write port of the `fifo` buffer between `NUM_REQ` producer requesters (e.g. protocol engines, ADC sampler, command decoder) in the same clock domain. It grants one requester at a time and forwards that requester's words onto `in_shift`/`in_data` with a valid/ready handshake gated by `in_full`, so no word is ever offered to a full FIFO. With bursts compiled in, a grant is held for a bounded burst so packets from one requester stay contiguous in the FIFO.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 16: data word width; must match the FIFO `WIDTH`.
- `MAX_BURST`, 8: maximum words per grant, 1..255; ignored when bursts are compiled out.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1: single clock, shared with the FIFO `in_clock`.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  NUM_REQ: bit i means requester i offers a word.
- `req_data`  in  NUM_REQ*WIDTH: requester i's word in bits [i*WIDTH +: WIDTH].
- `req_last`  in  NUM_REQ: bit i marks the final word of requester i's burst.
- `req_ready`  out  NUM_REQ: bit i means requester i's word is accepted this cycle.
- `fifo_shift`  out  1: drives FIFO `in_shift`.
- `fifo_data`  out  WIDTH: drives FIFO `in_data`.
- `fifo_full`  in  1: from FIFO `in_full`.
- `grant_valid`  out  1: a grant is active (state GRANT).
- `grant_id`  out  max(1,$clog2(NUM_REQ)): index of the current or last granted requester.
- `beat_count`  out  $clog2(MAX_BURST+1): words transferred in the current grant.

## Operation
- There are two states: IDLE and GRANT. Reset puts the block in IDLE, sets `grant_valid`=0, `grant_id`=0, `beat_count`=0 and the round-robin pointer `last` = NUM_REQ-1. Because the pointer starts at NUM_REQ-1, requester 0 wins first.
- **IDLE:** if any `req_valid` bit is set, select the first set bit searching `last+1, last+2, …` modulo NUM_REQ. Then:
  - register `grant_id` and set `last` to that index;
  - clear `beat_count`;
  - enter GRANT.
  
  If no bit is set, stay in IDLE.
- **GRANT:** a transfer occurs on a cycle where `xfer = req_valid[grant_id] && !fifo_full`. The outputs are combinational:
  - `fifo_shift = xfer`;
  - `fifo_data` = req_data slice `grant_id`;
  - `req_ready[grant_id] = !fifo_full`;
  - all other `req_ready` bits are 0.
  
  On each `xfer`, `beat_count` increments.
- **Release:** GRANT returns to IDLE at the end of a cycle where any of the following holds:
  - `xfer && req_last[grant_id]`;
  - `xfer` and `beat_count+1 == MAX_BURST`;
  - `!req_valid[grant_id]` (the requester withdrew).
- **Backpressure:** `fifo_full` holds GRANT indefinitely with no transfer; the requester must hold its data stable.
- In IDLE, `req_ready`=0 and `fifo_shift`=0.
- `beat_count` saturates at MAX_BURST and never wraps.
- Simultaneous `req_last` with the MAX_BURST limit produces a single release.

## Timing
- Arbitration latency: one cycle from `req_valid` rising in IDLE to GRANT.
- The first transfer can occur on the first GRANT cycle.
- There is one IDLE bubble cycle between consecutive grants. Peak throughput is therefore MAX_BURST words per MAX_BURST+1 cycles.
- `fifo_full` is sampled combinationally in the same cycle. The FIFO's look-ahead `in_full` guarantees that no accepted word is dropped.
- Reset mid-burst takes effect on the next clock edge. The block returns to IDLE, the pointer returns to NUM_REQ-1, and the word presented that cycle is not acknowledged (`req_ready` is forced to 0 while `reset` is high).

## Configuration
- **`FIFO_ARB_BURST_EN` defined:** the burst behaviour described above (release on last, MAX_BURST limit or withdraw).
- **`FIFO_ARB_BURST_EN` undefined:**
  - every grant releases after exactly one transfer;
  - `req_last` and `MAX_BURST` are ignored;
  - `beat_count` is held at 0 or 1.
  
  Words from different requesters interleave round-robin at one word per two cycles.

## Test plan
- **Reset:** assert `reset` for 2 cycles with all `req_valid`=1 -> `grant_valid`=0, `grant_id`=0, `beat_count`=0, `fifo_shift`=0, `req_ready`=0. After release, requester 0 is granted first.
- **Single burst:** requester 2 sends 0xA001, 0xA002, 0xA003 with `last` on the third word -> `grant_id`=2 one cycle later. Then `fifo_shift` is high for 3 consecutive cycles carrying those words in order, `beat_count` goes 1,2,3, and `grant_valid` falls the next cycle.
- **Fairness:** all 4 requesters request continuously with single-word bursts -> grant order 0,1,2,3,0,1 and each word reaches the FIFO.
- **Backpressure:** `fifo_full`=1 for 2 cycles during requester 1's second word -> `fifo_shift`=0 and `req_ready[1]`=0 for those cycles. The word transfers on the cycle `fifo_full` drops, with no duplicate or loss.
- **Burst limit:** with MAX_BURST=8, requester 0 streams 12 words without `last` while requester 3 is valid -> release after the 8th word, then requester 3 is granted, then requester 0 resumes at word 9.
- **Bursts compiled out:** `FIFO_ARB_BURST_EN` undefined with requesters 0 and 1 each sending 3 words -> FIFO receives 0,1,0,1,0,1 order, with one word every 2 cycles.
